// File: rtl/panel_frame_scroller_pkg.sv
// Shared constants and types for the LED panel frame scroller.
package panel_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_STATIC = 2'b11
  } mode_e;

  localparam logic [5:0] CH_0     = 6'd0;
  localparam logic [5:0] CH_A     = 6'd10;
  localparam logic [5:0] CH_SPACE = 6'd36;

  localparam int ROWS    = 5;
  localparam int COLS    = 7;
  localparam int GLYPH_W = 5;
  localparam int GAP_W   = 1;
  localparam int FRAME_W = ROWS * COLS;

  typedef logic [ROWS-1:0] glyph_col_t;

endpackage

// File: rtl/panel_frame_scroller_font_rom.sv
// 5x5 font: (code, column) -> one glyph column, bit r = row r (0 = top).
// Column 5 (inter-character gap), SPACE and codes 37..63 return an empty column.
module font_rom
  import panel_pkg::*;
(
  input  logic [5:0]  i_code,
  input  logic [2:0]  i_col,
  output glyph_col_t  o_col
);

  // Glyph rows packed top row first; within a row the MSB is the leftmost column.
  logic [24:0] w_rows;
  logic [4:0]  w_row [ROWS];

  always_comb begin
    w_rows = '0;
    case (i_code)
      6'd0:  w_rows = 25'b01110_10011_10101_11001_01110;
      6'd1:  w_rows = 25'b00100_01100_00100_00100_01110;
      6'd2:  w_rows = 25'b11110_00001_01110_10000_11111;
      6'd3:  w_rows = 25'b11110_00001_00110_00001_11110;
      6'd4:  w_rows = 25'b10010_10010_11111_00010_00010;
      6'd5:  w_rows = 25'b11111_10000_11110_00001_11110;
      6'd6:  w_rows = 25'b01110_10000_11110_10001_01110;
      6'd7:  w_rows = 25'b11111_00010_00100_01000_01000;
      6'd8:  w_rows = 25'b01110_10001_01110_10001_01110;
      6'd9:  w_rows = 25'b01110_10001_01111_00001_01110;
      6'd10: w_rows = 25'b01110_10001_11111_10001_10001;
      6'd11: w_rows = 25'b11110_10001_11110_10001_11110;
      6'd12: w_rows = 25'b01111_10000_10000_10000_01111;
      6'd13: w_rows = 25'b11110_10001_10001_10001_11110;
      6'd14: w_rows = 25'b11111_10000_11110_10000_11111;
      6'd15: w_rows = 25'b11111_10000_11110_10000_10000;
      6'd16: w_rows = 25'b01111_10000_10011_10001_01111;
      6'd17: w_rows = 25'b10001_10001_11111_10001_10001;
      6'd18: w_rows = 25'b11111_00100_00100_00100_11111;
      6'd19: w_rows = 25'b00111_00010_00010_10010_01100;
      6'd20: w_rows = 25'b10010_10100_11000_10100_10010;
      6'd21: w_rows = 25'b10000_10000_10000_10000_11111;
      6'd22: w_rows = 25'b10001_11011_10101_10001_10001;
      6'd23: w_rows = 25'b10001_11001_10101_10011_10001;
      6'd24: w_rows = 25'b01110_10001_10001_10001_01110;
      6'd25: w_rows = 25'b11110_10001_11110_10000_10000;
      6'd26: w_rows = 25'b01110_10001_10101_10010_01101;
      6'd27: w_rows = 25'b11110_10001_11110_10100_10010;
      6'd28: w_rows = 25'b01111_10000_01110_00001_11110;
      6'd29: w_rows = 25'b11111_00100_00100_00100_00100;
      6'd30: w_rows = 25'b10001_10001_10001_10001_01110;
      6'd31: w_rows = 25'b10001_10001_10001_01010_00100;
      6'd32: w_rows = 25'b10001_10001_10101_11011_10001;
      6'd33: w_rows = 25'b10001_01010_00100_01010_10001;
      6'd34: w_rows = 25'b10001_01010_00100_00100_00100;
      6'd35: w_rows = 25'b11111_00010_00100_01000_11111;
      default: w_rows = '0;
    endcase
  end

  always_comb begin
    o_col = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_row[r] = w_rows[(ROWS-1-r)*GLYPH_W +: GLYPH_W];
      if (i_col < 3'(GLYPH_W))
        o_col[r] = w_row[r][3'd4 - i_col];
    end
  end

endmodule

// File: rtl/panel_frame_scroller.sv
// Scrolls buffered characters through a 5x7 frame one column per tick; PANEL_BLINK_EN adds static-mode blinking.
// Frame changes one cycle after a scroll tick or mode change; there is no backpressure (frame_upd is a pulse).
module panel_frame_scroller
  import panel_pkg::*;
#(
  parameter int MSG_LEN     = 8,
  parameter int TICK_DIV    = 2500000,
  parameter int BLINK_TICKS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ch1,
  input  logic                       ch0,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [5:0]                 wr_char,
  output logic [FRAME_W-1:0]         frame,
  output logic                       frame_upd
);

  localparam int         AW       = $clog2(MSG_LEN);
  localparam int         PW       = $clog2(TICK_DIV);
  localparam logic [2:0] LAST_COL = 3'(GLYPH_W + GAP_W - 1);

  if (MSG_LEN < 2 || MSG_LEN > 16 || TICK_DIV < 2 || BLINK_TICKS < 1) begin : g_bad_params
    $error("panel_frame_scroller: parameter out of range");
  end

  mode_e              r_mode, w_mode_in, w_mode_nxt;
  logic               w_mode_chg, w_tick, w_shift_l, w_shift_r, w_blink_tgl, w_upd_nxt;
  logic [5:0]         r_buf [MSG_LEN];
  logic [FRAME_W-1:0] r_frame, w_shl, w_shr;
  logic [PW-1:0]      r_presc;
  logic [AW-1:0]      r_char;
  logic [2:0]         r_col;
  logic               r_upd;
  logic [5:0]         w_code;
  glyph_col_t         w_glyph;

  assign w_mode_in  = mode_e'({ch1, ch0});
  assign w_mode_chg = (w_mode_in != r_mode);
  assign w_tick     = (r_mode != MODE_OFF) && (r_presc == PW'(TICK_DIV - 1));
  assign w_code     = r_buf[r_char];

  font_rom u_font (
    .i_code (w_code),
    .i_col  (r_col),
    .o_col  (w_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= MODE_OFF;
    else        r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_mode_chg) w_mode_nxt = w_mode_in;
  end

  // A mode change wins over a coincident tick: the frame is cleared, not shifted.
  always_comb begin
    w_shift_l = w_tick && !w_mode_chg && (r_mode == MODE_LEFT);
    w_shift_r = w_tick && !w_mode_chg && (r_mode == MODE_RIGHT);
    w_upd_nxt = w_mode_chg || w_shift_l || w_shift_r || w_blink_tgl;
  end

  always_comb begin
    w_shl = '0;
    w_shr = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS-1; c++) begin
        w_shl[r*COLS + c]     = r_frame[r*COLS + c + 1];
        w_shr[r*COLS + c + 1] = r_frame[r*COLS + c];
      end
      w_shl[r*COLS + COLS-1] = w_glyph[r];
      w_shr[r*COLS]          = w_glyph[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) r_buf[i] <= CH_SPACE;
      r_frame <= '0;
      r_presc <= '0;
      r_char  <= '0;
      r_col   <= '0;
      r_upd   <= 1'b0;
    end else begin
      if (wr_en && (int'(wr_addr) < MSG_LEN)) r_buf[wr_addr] <= wr_char;
      r_upd <= w_upd_nxt;
      if (w_mode_chg) begin
        r_frame <= '0;
        r_presc <= '0;
        if (w_mode_in == MODE_LEFT) begin
          r_char <= '0;
          r_col  <= '0;
        end else if (w_mode_in == MODE_RIGHT) begin
          r_char <= AW'(MSG_LEN - 1);
          r_col  <= LAST_COL;
        end
      end else begin
        if (r_mode == MODE_OFF || w_tick) r_presc <= '0;
        else                              r_presc <= r_presc + PW'(1);
        if (w_shift_l) begin
          r_frame <= w_shl;
          if (r_col == LAST_COL) begin
            r_col  <= '0;
            r_char <= (r_char == AW'(MSG_LEN - 1)) ? '0 : r_char + AW'(1);
          end else begin
            r_col  <= r_col + 3'd1;
          end
        end else if (w_shift_r) begin
          r_frame <= w_shr;
          if (r_col == 3'd0) begin
            r_col  <= LAST_COL;
            r_char <= (r_char == '0) ? AW'(MSG_LEN - 1) : r_char - AW'(1);
          end else begin
            r_col  <= r_col - 3'd1;
          end
        end
      end
    end
  end

`ifdef PANEL_BLINK_EN
  localparam int BW = $clog2(BLINK_TICKS + 1);
  logic [BW-1:0] r_bcnt;
  logic          r_blank;

  assign w_blink_tgl = w_tick && !w_mode_chg && (r_mode == MODE_STATIC)
                       && (r_bcnt == BW'(BLINK_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_blank <= 1'b0;
    end else if (w_mode_chg) begin
      r_bcnt  <= '0;
      r_blank <= 1'b0;
    end else if (w_tick && r_mode == MODE_STATIC) begin
      if (w_blink_tgl) begin
        r_bcnt  <= '0;
        r_blank <= ~r_blank;
      end else begin
        r_bcnt  <= r_bcnt + BW'(1);
      end
    end
  end

  assign frame = r_blank ? '0 : r_frame;
`else
  assign w_blink_tgl = 1'b0;
  assign frame       = r_frame;
`endif

  assign frame_upd = r_upd;

endmodule

// File: tb/tb_panel_frame_scroller.sv
// Directed bench with a column-array reference model; expected frames are queued per tick and checked on frame_upd.
module tb_panel_frame_scroller;
  import panel_pkg::*;

  localparam int MSG_LEN  = 3;
  localparam int TICK_DIV = 4;
  localparam int AW       = 2;

  typedef logic [4:0] col_t;
  typedef struct { int cyc; logic [34:0] frm; } exp_t;

  logic          clk = 1'b0, rst_n = 1'b0, ch1 = 1'b0, ch0 = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [5:0]    wr_char = '0;
  logic [34:0]   frame;
  logic          frame_upd;

  panel_frame_scroller #(.MSG_LEN(MSG_LEN), .TICK_DIV(TICK_DIV), .BLINK_TICKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .ch1(ch1), .ch0(ch0), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_char(wr_char), .frame(frame), .frame_upd(frame_upd)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc++;

  int   vectors = 0, miscompares = 0;
  exp_t sb[$];

  logic [5:0] mbuf [MSG_LEN];
  col_t       mc [7];
  int         mchar, mcol, mtick;
  logic [1:0] mmode;

  // Reference glyph table for the codes the bench uses (rows top-first, MSB = leftmost column).
  function automatic col_t gcol(input logic [5:0] code, input int col);
    logic [24:0] rows;
    case (code)
      6'd1:    rows = 25'b00100_01100_00100_00100_01110;
      6'd10:   rows = 25'b01110_10001_11111_10001_10001;
      6'd35:   rows = 25'b11111_00010_00100_01000_11111;
      default: rows = '0;
    endcase
    gcol = '0;
    if (col < 5)
      for (int r = 0; r < 5; r++) gcol[r] = rows[(4-r)*5 + (4-col)];
  endfunction

  function automatic logic [34:0] pack7(input col_t a0, a1, a2, a3, a4, a5, a6);
    col_t a [7];
    a = '{a0, a1, a2, a3, a4, a5, a6};
    pack7 = '0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 5; r++) pack7[r*7 + c] = a[c][r];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && frame_upd === 1'b1) begin
      chk("upd_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("upd_cycle", 64'(cyc), 64'(e.cyc));
        chk("upd_frame", 64'(frame), 64'(e.frm));
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < MSG_LEN; i++) mbuf[i] = 6'd36;
    for (int c = 0; c < 7; c++) mc[c] = '0;
    mchar = 0; mcol = 0; mmode = 2'b00;
  endtask

  task automatic set_mode(input logic [1:0] m);
    {ch1, ch0} = m;
    sb.push_back('{cyc + 1, 35'd0});
    for (int c = 0; c < 7; c++) mc[c] = '0;
    mmode = m;
    if (m == 2'b01) begin mchar = 0; mcol = 0; end
    else if (m == 2'b10) begin mchar = MSG_LEN - 1; mcol = 5; end
    mtick = cyc + 1 + TICK_DIV;
    wait_cyc(cyc + 1);
    chk("mode_drain", 64'(sb.size()), 64'd0);
  endtask

  // Advance the model by one tick and queue the frame the DUT must show at that tick.
  task automatic tick_model();
    col_t g;
    g = gcol(mbuf[mchar], mcol);
    if (mmode == 2'b01) begin
      for (int c = 0; c < 6; c++) mc[c] = mc[c+1];
      mc[6] = g;
      mcol++;
      if (mcol > 5) begin mcol = 0; mchar = (mchar + 1) % MSG_LEN; end
    end else begin
      for (int c = 6; c > 0; c--) mc[c] = mc[c-1];
      mc[0] = g;
      mcol--;
      if (mcol < 0) begin mcol = 5; mchar = (mchar == 0) ? MSG_LEN - 1 : mchar - 1; end
    end
    sb.push_back('{mtick, pack7(mc[0], mc[1], mc[2], mc[3], mc[4], mc[5], mc[6])});
    mtick += TICK_DIV;
  endtask

  task automatic run_ticks(input int n);
    int tgt;
    for (int i = 0; i < n; i++) begin
      tgt = mtick;
      tick_model();
      wait_cyc(tgt);
    end
    chk("tick_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic write_buf(input int a, input logic [5:0] code);
    wr_en = 1'b1; wr_addr = AW'(a); wr_char = code;
    wait_cyc(cyc + 1);
    wr_en = 1'b0;
    if (a < MSG_LEN) mbuf[a] = code;
  endtask

  initial begin
    int tgt, slot;
    model_reset();
    wait_cyc(3);
    chk("rst_frame", 64'(frame), 64'd0);
    chk("rst_upd", 64'(frame_upd), 64'd0);
    rst_n = 1'b1;
    wait_cyc(cyc + 5);
    chk("off_frame", 64'(frame), 64'd0);

    write_buf(0, 6'd1);
    write_buf(MSG_LEN - 1, 6'd10);

    set_mode(2'b01);
    run_ticks(7);
    chk("left7", 64'(frame), 64'(pack7(gcol(1,0), gcol(1,1), gcol(1,2), gcol(1,3), gcol(1,4), 5'd0, 5'd0)));

    set_mode(2'b11);
    wait_cyc(cyc + 10);
    chk("static_frame", 64'(frame), 64'd0);

    set_mode(2'b01);
    run_ticks(19);
    chk("left_wrap", 64'(frame),
        64'(pack7(gcol(10,0), gcol(10,1), gcol(10,2), gcol(10,3), gcol(10,4), 5'd0, gcol(1,0))));

    set_mode(2'b10);
    run_ticks(6);
    chk("right6", 64'(frame),
        64'(pack7(gcol(10,0), gcol(10,1), gcol(10,2), gcol(10,3), gcol(10,4), 5'd0, 5'd0)));
    run_ticks(1);
    chk("right7", 64'(frame),
        64'(pack7(5'd0, gcol(10,0), gcol(10,1), gcol(10,2), gcol(10,3), gcol(10,4), 5'd0)));

    // Rewrite the slot being fetched in the very cycle its tick fires.
    tgt  = mtick;
    slot = mchar;
    wait_cyc(tgt - 1);
    wr_en = 1'b1; wr_addr = AW'(slot); wr_char = 6'd35;
    tick_model();
    mbuf[slot] = 6'd35;
    wait_cyc(tgt);
    wr_en = 1'b0;
    run_ticks(4);
    chk("collision", 64'(frame),
        64'(pack7(gcol(35,0), gcol(35,1), gcol(35,2), gcol(35,3), 5'd0, 5'd0, gcol(10,0))));

    write_buf(MSG_LEN, 6'd35);
    run_ticks(6);

    {ch1, ch0} = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("arst_frame", 64'(frame), 64'd0);
    chk("arst_upd", 64'(frame_upd), 64'd0);
    sb.delete();
    model_reset();
    wait_cyc(cyc + 2);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wait_cyc(cyc + 1);
      chk("post_rst_frame", 64'(frame), 64'd0);
    end

    set_mode(2'b01);
    run_ticks(6);
    chk("buf_reset_blank", 64'(frame), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
